key_schedule: RTL

KEY_SCHEDULE -- requirements
Module: key_schedule

---
 rtl/key_schedule.sv | 120 ++++++++++++
 1 files changed

// File: rtl/key_schedule.sv
// AES-128 key schedule: emits round keys 0..10, one per cycle, after key_load.
// Ports: clk, rst (async, active-low), key_load, key_in, [stall if KEYSCHED_STALL_EN] -> rkey, addr, rkey_valid, busy, done.
module key_schedule (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_load,
  input  logic [127:0] key_in,
`ifdef KEYSCHED_STALL_EN
  input  logic         stall,
`endif
  output logic [127:0] rkey,
  output logic [3:0]   addr,
  output logic         rkey_valid,
  output logic         busy,
  output logic         done
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] GEN  = 1'b1;

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic [0:0]  state;
  logic        hold;
  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rot, sub;
  logic [31:0] n0, n1, n2, n3;
  logic [7:0]  rcon;

`ifdef KEYSCHED_STALL_EN
  assign hold = stall;
`else
  assign hold = 1'b0;
`endif

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[11'd2047 - {b, 3'b000} -: 8];
  endfunction

  // Rcon for the round being produced (addr + 1)
  always_comb begin
    rcon = 8'h00;
    case (addr)
      4'd0:    rcon = 8'h01;
      4'd1:    rcon = 8'h02;
      4'd2:    rcon = 8'h04;
      4'd3:    rcon = 8'h08;
      4'd4:    rcon = 8'h10;
      4'd5:    rcon = 8'h20;
      4'd6:    rcon = 8'h40;
      4'd7:    rcon = 8'h80;
      4'd8:    rcon = 8'h1b;
      4'd9:    rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  assign w0  = rkey[127:96];
  assign w1  = rkey[95:64];
  assign w2  = rkey[63:32];
  assign w3  = rkey[31:0];
  assign rot = {w3[23:0], w3[31:24]};
  assign sub = {sbox(rot[31:24]), sbox(rot[23:16]),
                sbox(rot[15:8]),  sbox(rot[7:0])};
  assign n0  = w0 ^ sub ^ {rcon, 24'h0};
  assign n1  = w1 ^ n0;
  assign n2  = w2 ^ n1;
  assign n3  = w3 ^ n2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      rkey  <= '0;
      addr  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (key_load) begin
            rkey  <= key_in;
            addr  <= 4'd0;
            state <= GEN;
          end
        end
        GEN: begin
          if (!hold) begin
            if (addr == 4'hA) begin
              state <= IDLE;
            end else begin
              rkey <= {n0, n1, n2, n3};
              addr <= addr + 4'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy       = (state == GEN);
  assign rkey_valid = busy;
  assign done       = busy && (addr == 4'hA);

endmodule
